// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use / memory-freeze hazard control for the integer pipeline.
// Forward selects are purely combinational; the load-use bubble sequencer and statistics are registered.
module fwd_hazard_ctrl #(
    parameter int NUM_SRC      = 2,
    parameter int NUM_STG      = 2,
    parameter int RA_W         = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int STAT_W       = 16,
    localparam int SEL_W       = $clog2(NUM_STG + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*RA_W-1:0]    ex_rs,
    input  logic [NUM_SRC-1:0]         ex_rs_used,
    input  logic [NUM_STG*RA_W-1:0]    stg_rd,
    input  logic [NUM_STG-1:0]         stg_regwrite,
    input  logic                       id_valid,
    input  logic [NUM_SRC*RA_W-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]         id_rs_used,
    input  logic                       ex_valid,
    input  logic                       ex_is_load,
    input  logic [RA_W-1:0]            ex_rd,
    input  logic                       mem_busy,
    input  logic                       flush,
    input  logic                       stat_clr,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       stall_pc,
    output logic                       stall_ifid,
    output logic                       bubble_idex,
    output logic                       freeze_all,
    output logic [STAT_W-1:0]          stat_lu_stalls,
    output logic [STAT_W-1:0]          stat_fwd_hits
);

    typedef enum logic {IDLE, LU_STALL} state_t;

    localparam logic [3:0]        CNT_INIT = (LOAD_BUBBLES > 1) ? 4'(LOAD_BUBBLES - 2) : 4'd0;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    state_t               state_reg, state_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic [NUM_SRC-1:0]   id_match;
    logic                 lu_hit;
    logic                 lu_stall;

    // Older stages are scanned first so the youngest matching stage overwrites them.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
        logic [SEL_W-1:0] sel;
        always_comb begin
            sel = '0;
            for (int k = NUM_STG - 1; k >= 0; k--) begin
                if (stg_regwrite[k] && (stg_rd[k*RA_W +: RA_W] != '0) &&
                    (stg_rd[k*RA_W +: RA_W] == ex_rs[gi*RA_W +: RA_W]) && ex_rs_used[gi]) begin
                    sel = SEL_W'(k + 1);
                end
            end
        end
        assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
        assign id_match[gi] = id_rs_used[gi] && (id_rs[gi*RA_W +: RA_W] == ex_rd);
    end

    assign lu_hit = ex_valid && ex_is_load && (ex_rd != '0) && id_valid && (|id_match);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        lu_stall   = 1'b0;
        case (state_reg)
            IDLE: begin
                lu_stall = lu_hit;
                if (lu_hit && !flush && !mem_busy && (LOAD_BUBBLES > 1)) begin
                    state_next = LU_STALL;
                    cnt_next   = CNT_INIT;
                end
            end
            LU_STALL: begin
                lu_stall = 1'b1;
                if (!mem_busy) begin
                    if (cnt_reg == 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A redirect abandons any pending bubbles, even while the pipe is frozen.
        if (flush) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
        end
    end

    assign stall_pc    = (lu_stall && !flush) || mem_busy;
    assign stall_ifid  = stall_pc;
    assign bubble_idex = lu_stall && !flush && !mem_busy;
    assign freeze_all  = mem_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lu_stalls <= '0;
            stat_fwd_hits  <= '0;
        end else if (stat_clr) begin
            stat_lu_stalls <= '0;
            stat_fwd_hits  <= '0;
        end else begin
            if (bubble_idex && (stat_lu_stalls != STAT_MAX)) begin
                stat_lu_stalls <= stat_lu_stalls + 1'b1;
            end
            if ((|fwd_sel) && (stat_fwd_hits != STAT_MAX)) begin
                stat_fwd_hits <= stat_fwd_hits + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Two controller instances (1 bubble / 4-bit stats, 3 bubbles / 16-bit stats) driven by shared
// directed and random stimulus, checked against a bubbles-owed reference model.
module tb_fwd_hazard_ctrl;
    localparam int NS = 2;
    localparam int NG = 2;
    localparam int RW = 5;
    localparam int SW = 2;
    localparam int LB_A = 1;
    localparam int LB_B = 3;
    localparam int MAX_A = 15;
    localparam int MAX_B = 65535;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NS*RW-1:0] ex_rs, id_rs;
    logic [NS-1:0]    ex_rs_used, id_rs_used;
    logic [NG*RW-1:0] stg_rd;
    logic [NG-1:0]    stg_regwrite;
    logic             id_valid, ex_valid, ex_is_load, mem_busy, flush, stat_clr;
    logic [RW-1:0]    ex_rd;

    logic [NS*SW-1:0] a_fwd_sel, b_fwd_sel;
    logic a_stall_pc, a_stall_ifid, a_bubble, a_freeze;
    logic b_stall_pc, b_stall_ifid, b_bubble, b_freeze;
    logic [3:0]  a_lu, a_fw;
    logic [15:0] b_lu, b_fw;

    fwd_hazard_ctrl #(.NUM_SRC(NS), .NUM_STG(NG), .RA_W(RW), .LOAD_BUBBLES(LB_A), .STAT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .ex_rs_used(ex_rs_used), .stg_rd(stg_rd),
        .stg_regwrite(stg_regwrite), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .mem_busy(mem_busy),
        .flush(flush), .stat_clr(stat_clr), .fwd_sel(a_fwd_sel), .stall_pc(a_stall_pc),
        .stall_ifid(a_stall_ifid), .bubble_idex(a_bubble), .freeze_all(a_freeze),
        .stat_lu_stalls(a_lu), .stat_fwd_hits(a_fw));

    fwd_hazard_ctrl #(.NUM_SRC(NS), .NUM_STG(NG), .RA_W(RW), .LOAD_BUBBLES(LB_B), .STAT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .ex_rs_used(ex_rs_used), .stg_rd(stg_rd),
        .stg_regwrite(stg_regwrite), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .mem_busy(mem_busy),
        .flush(flush), .stat_clr(stat_clr), .fwd_sel(b_fwd_sel), .stall_pc(b_stall_pc),
        .stall_ifid(b_stall_ifid), .bubble_idex(b_bubble), .freeze_all(b_freeze),
        .stat_lu_stalls(b_lu), .stat_fwd_hits(b_fw));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rem_a = 0, rem_b = 0;      // bubbles still owed after the current cycle
    int lu_a = 0, lu_b = 0, fw_a = 0, fw_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] ref_sel(input int i);
        for (int k = 0; k < NG; k++) begin
            if (stg_regwrite[k] && stg_rd[k*RW +: RW] != 0 &&
                stg_rd[k*RW +: RW] == ex_rs[i*RW +: RW] && ex_rs_used[i])
                return SW'(k + 1);
        end
        return '0;
    endfunction

    function automatic bit ref_hit();
        bit any = 0;
        for (int i = 0; i < NS; i++)
            if (id_rs_used[i] && id_rs[i*RW +: RW] == ex_rd) any = 1;
        return ex_valid && ex_is_load && ex_rd != 0 && id_valid && any;
    endfunction

    function automatic int next_rem(input int rem, input bit act, input int lb);
        if (flush) return 0;
        if (mem_busy) return rem;
        if (rem > 0) return rem - 1;
        if (act) return lb - 1;
        return 0;
    endfunction

    function automatic int sat_inc(input int v, input bit inc, input int mx);
        if (stat_clr) return 0;
        if (inc && v < mx) return v + 1;
        return v;
    endfunction

    // Called at a falling edge after inputs are driven; ends at the next falling edge.
    task automatic cycle(input string tag);
        bit hit, act_a, act_b, bub_a, bub_b, any_fwd;
        #1;
        hit = ref_hit();
        any_fwd = 0;
        for (int i = 0; i < NS; i++) begin
            if (ref_sel(i) != 0) any_fwd = 1;
            chk({tag, "_a_fwd"}, 32'(a_fwd_sel[i*SW +: SW]), 32'(ref_sel(i)));
            chk({tag, "_b_fwd"}, 32'(b_fwd_sel[i*SW +: SW]), 32'(ref_sel(i)));
        end
        act_a = (rem_a > 0) || hit;
        act_b = (rem_b > 0) || hit;
        bub_a = act_a && !flush && !mem_busy;
        bub_b = act_b && !flush && !mem_busy;
        chk({tag, "_a_bubble"}, 32'(a_bubble), 32'(bub_a));
        chk({tag, "_b_bubble"}, 32'(b_bubble), 32'(bub_b));
        chk({tag, "_a_stall_pc"}, 32'(a_stall_pc), 32'((act_a && !flush) || mem_busy));
        chk({tag, "_b_stall_pc"}, 32'(b_stall_pc), 32'((act_b && !flush) || mem_busy));
        chk({tag, "_a_stall_ifid"}, 32'(a_stall_ifid), 32'((act_a && !flush) || mem_busy));
        chk({tag, "_b_stall_ifid"}, 32'(b_stall_ifid), 32'((act_b && !flush) || mem_busy));
        chk({tag, "_a_freeze"}, 32'(a_freeze), 32'(mem_busy));
        chk({tag, "_b_freeze"}, 32'(b_freeze), 32'(mem_busy));
        @(posedge clk);
        rem_a = next_rem(rem_a, act_a, LB_A);
        rem_b = next_rem(rem_b, act_b, LB_B);
        lu_a = sat_inc(lu_a, bub_a, MAX_A);
        lu_b = sat_inc(lu_b, bub_b, MAX_B);
        fw_a = sat_inc(fw_a, any_fwd, MAX_A);
        fw_b = sat_inc(fw_b, any_fwd, MAX_B);
        #1;
        chk({tag, "_a_stat_lu"}, 32'(a_lu), 32'(lu_a));
        chk({tag, "_b_stat_lu"}, 32'(b_lu), 32'(lu_b));
        chk({tag, "_a_stat_fwd"}, 32'(a_fw), 32'(fw_a));
        chk({tag, "_b_stat_fwd"}, 32'(b_fw), 32'(fw_b));
        $display("cycle %s: a_bub=%0b b_bub=%0b stall=%0b/%0b fwd=%h lu=%0d/%0d fw=%0d/%0d",
                 tag, a_bubble, b_bubble, a_stall_pc, b_stall_pc, a_fwd_sel, a_lu, b_lu, a_fw, b_fw);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ex_rs = '0; ex_rs_used = '0; stg_rd = '0; stg_regwrite = '0;
        id_rs = '0; id_rs_used = '0; id_valid = 0; ex_valid = 0; ex_is_load = 0;
        ex_rd = '0; mem_busy = 0; flush = 0; stat_clr = 0;
    endtask

    task automatic load_use(input logic [RW-1:0] rd);
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
        id_valid = 1; id_rs = {rd, 5'd0}; id_rs_used = 2'b10;
    endtask

    initial begin
        clear_inputs();
        #2;
        chk("reset_a_stall", 32'(a_stall_pc), 32'd0);
        chk("reset_b_bubble", 32'(b_bubble), 32'd0);
        chk("reset_a_stat_lu", 32'(a_lu), 32'd0);
        chk("reset_b_stat_fwd", 32'(b_fw), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Youngest stage wins; unused operand never forwards.
        ex_rs = {5'd5, 5'd5}; ex_rs_used = 2'b01; stg_rd = {5'd5, 5'd5}; stg_regwrite = 2'b11;
        #1;
        chk("t1_sel0", 32'(a_fwd_sel[1:0]), 32'd1);
        chk("t1_sel1", 32'(a_fwd_sel[3:2]), 32'd0);
        cycle("t1");

        // x0 in the young stage is ignored; both operands take the older stage.
        ex_rs = {5'd7, 5'd7}; ex_rs_used = 2'b11; stg_rd = {5'd7, 5'd0}; stg_regwrite = 2'b11;
        #1;
        chk("t2_sel", 32'(b_fwd_sel), 32'hA);
        cycle("t2");
        clear_inputs();

        // Single load-use hazard: A stalls 1 cycle, B stalls 3.
        load_use(5'd3);
        cycle("t3_hit");
        clear_inputs();
        for (int i = 0; i < 3; i++) cycle("t3_tail");
        chk("t3_a_lu_total", 32'(a_lu), 32'd1);
        chk("t3_b_lu_total", 32'(b_lu), 32'd3);

        // Freeze in the middle of B's bubble sequence.
        load_use(5'd3);
        cycle("t4_hit");
        clear_inputs();
        mem_busy = 1;
        #1;
        chk("t4_freeze", 32'(b_freeze), 32'd1);
        chk("t4_no_bubble", 32'(b_bubble), 32'd0);
        cycle("t4_busy");
        cycle("t4_busy");
        mem_busy = 0;
        for (int i = 0; i < 3; i++) cycle("t4_resume");
        chk("t4_b_lu_total", 32'(b_lu), 32'd6);

        // Flush during B's second stall cycle drops it and returns to idle.
        load_use(5'd3);
        cycle("t5_hit");
        clear_inputs();
        flush = 1;
        #1;
        chk("t5_flush_bubble", 32'(b_bubble), 32'd0);
        cycle("t5_flush");
        flush = 0;
        cycle("t5_idle");

        // Asynchronous reset while B is mid-stall.
        load_use(5'd3);
        cycle("t5_hit2");
        clear_inputs();
        #2;
        chk("t5_pre_rst_stall", 32'(b_stall_pc), 32'd1);
        rst_n = 0;
        #1;
        chk("t5_rst_stall", 32'(b_stall_pc), 32'd0);
        chk("t5_rst_ifid", 32'(b_stall_ifid), 32'd0);
        chk("t5_rst_bubble", 32'(b_bubble), 32'd0);
        chk("t5_rst_stat", 32'(b_lu), 32'd0);
        rem_a = 0; rem_b = 0; lu_a = 0; lu_b = 0; fw_a = 0; fw_b = 0;
        @(negedge clk);
        rst_n = 1;

        // Saturation of the 4-bit forward counter, then clear.
        ex_rs = {5'd0, 5'd9}; ex_rs_used = 2'b01; stg_rd = {5'd0, 5'd9}; stg_regwrite = 2'b01;
        for (int i = 0; i < 20; i++) cycle("t6_fwd");
        chk("t6_a_sat", 32'(a_fw), 32'd15);
        chk("t6_b_count", 32'(b_fw), 32'd20);
        stat_clr = 1;
        cycle("t6_clr");
        chk("t6_a_clr", 32'(a_fw), 32'd0);
        stat_clr = 0;
        clear_inputs();

        // Randomised traffic over a small register range so hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            ex_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            stg_rd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ex_rs_used = 2'($urandom);
            id_rs_used = 2'($urandom);
            stg_regwrite = 2'($urandom);
            ex_rd = 5'($urandom_range(0, 3));
            ex_valid = ($urandom_range(0, 3) != 0);
            id_valid = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 1) != 0);
            mem_busy = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 11) == 0);
            stat_clr = ($urandom_range(0, 29) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
